econet_handshake_ctrl: RTL and testbench
========================================

ECONET_HANDSHAKE_CTRL -- requirements
Module: econet_handshake_ctrl

Interface
REQ-001 SHALL have parameter SCOUT_MAX, default 8, maximum byte count (incl. FCS) classed as a scout frame.
REQ-002 SHALL have parameter TO_WIDTH, default 20, width of the data-wait timer.
REQ-003 SHALL have parameter TIMEOUT, default 500000, sys_clk cycles allowed between scout ACK completion and data frame arrival.
REQ-004 Ports (name  direction  width  meaning):
  sys_clk  in  1  sole clock
  reset_n  in  1  asynchronous, active-low reset
  enable  in  1  accept new handshakes
  listen_port  in  8  port to accept; 0 = any nonzero port
  frame_valid  in  1  receiver's synchronized valid-frame level
  frame_cnt  in  11  byte count of the held frame
  frame_src  in  16  held frame source {net, station}
  frame_scout  in  16  held frame {ctrl[15:8], port[7:0]}
  frame_clear  out  1  one-cycle pulse clearing the receiver's valid flag
  tx_req  out  1  ACK transmit request
  tx_dst  out  16  ACK destination {net, station}
  tx_done  in  1  one-cycle pulse, ACK sent
  tx_err  in  1  one-cycle pulse, ACK failed
  hs_ctrl  out  8  latched scout control byte
  hs_port  out  8  latched scout port
  hs_len  out  11  payload length of completed data frame
  err_code  out  2  0 none, 1 timeout, 2 ACK1 fail, 3 ACK2 fail
  irq  out  1  sticky completion/error interrupt
  irq_ack  in  1  clears irq
  state  out  3  current FSM state encoding

Function
REQ-005 SHALL implement FSM states IDLE=0, ACK1=1, WAIT_DATA=2, ACK2=3.
REQ-006 SHALL detect a new frame as the 0->1 edge of frame_valid, registered once (previous-value flop); level held high SHALL NOT retrigger.
REQ-007 On every new-frame edge, in any state, SHALL assert frame_clear exactly one cycle, in the cycle after the edge is detected.
REQ-008 IDLE: new frame with enable=1, frame_cnt<=SCOUT_MAX, port!=0, and (listen_port==0 or port==listen_port) SHALL latch frame_src, hs_ctrl, hs_port and go ACK1 next cycle; any other frame SHALL be ignored (state unchanged).
REQ-009 ACK1/ACK2: tx_req SHALL be 1 with tx_dst = latched source; tx_req SHALL stay high until tx_done or tx_err and drop in the cycle after either.
REQ-010 ACK1: tx_done -> WAIT_DATA with timer cleared to 0; tx_err -> IDLE, err_code=2, irq set.
REQ-011 WAIT_DATA: timer SHALL increment each cycle; new frame with frame_src==latched source and frame_cnt>4 -> ACK2, hs_len = frame_cnt-4 (11-bit, no wrap possible); frame from other source or frame_cnt<=4 SHALL be ignored, timer not reset.
REQ-012 WAIT_DATA: timer reaching TIMEOUT-1 -> IDLE, err_code=1, irq set; a qualifying frame in the same cycle SHALL take priority (-> ACK2).
REQ-013 ACK2: tx_done -> IDLE, err_code=0, irq set; tx_err -> IDLE, err_code=3, irq set.
REQ-014 enable=0 in WAIT_DATA SHALL return to IDLE next cycle without irq; in ACK1/ACK2 the transmit SHALL complete first, then go IDLE (no WAIT_DATA, no irq on done; error still reported).
REQ-015 irq SHALL remain set until irq_ack=1; set and irq_ack in the same cycle -> irq stays 1.
REQ-016 tx_done and tx_err together SHALL be treated as tx_err.
REQ-017 hs_ctrl, hs_port, hs_len, err_code SHALL hold until overwritten by the next event.

Reset
REQ-018 reset_n=0 SHALL immediately force state=IDLE, tx_req=0, frame_clear=0, irq=0, err_code=0, tx_dst=0, hs_ctrl=0, hs_port=0, hs_len=0, timer=0, edge flop=0.
REQ-019 Reset mid-ACK SHALL drop tx_req at once; a frame_valid already high at release SHALL be seen as a new edge.

Verification
REQ-020 Scout cnt=6, port 0x99, src 0x0102, listen_port=0; tx_done; data src 0x0102 cnt=20; tx_done -> two ACKs to 0x0102, hs_len=16, err_code=0, irq=1, state=0.
REQ-021 Scout accepted, ACK1 done, no data frame -> IDLE exactly TIMEOUT cycles after ACK1 completion, err_code=1, irq=1.
REQ-022 In WAIT_DATA, frame from src 0x0305 -> frame_clear pulse, state stays 2; then correct src -> ACK2.
REQ-023 tx_err during ACK1 -> err_code=2, irq=1, state=0; irq_ack -> irq=0.
REQ-024 listen_port=0x10, scout port 0x11 or port 0 -> frame_clear only, tx_req never asserted.
REQ-025 reset_n low during ACK2 with tx_req=1 -> tx_req=0, state=0 asynchronously; all outputs at REQ-018 values.

Source files
------------

// File: rtl/econet_handshake_ctrl.sv
// Econet four-way handshake receiver controller: scout detection, ACK requests,
// data-frame wait with timeout, and sticky completion/error interrupt.
module econet_handshake_ctrl #(
    parameter int SCOUT_MAX = 8,
    parameter int TO_WIDTH  = 20,
    parameter int TIMEOUT   = 500000
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  listen_port,
    input  logic        frame_valid,
    input  logic [10:0] frame_cnt,
    input  logic [15:0] frame_src,
    input  logic [15:0] frame_scout,
    output logic        frame_clear,
    output logic        tx_req,
    output logic [15:0] tx_dst,
    input  logic        tx_done,
    input  logic        tx_err,
    output logic [7:0]  hs_ctrl,
    output logic [7:0]  hs_port,
    output logic [10:0] hs_len,
    output logic [1:0]  err_code,
    output logic        irq,
    input  logic        irq_ack,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACK1      = 3'd1,
        WAIT_DATA = 3'd2,
        ACK2      = 3'd3
    } state_t;

    localparam logic [10:0]         SCOUT_MAX_C = 11'(SCOUT_MAX);
    localparam logic [TO_WIDTH-1:0] TO_LAST     = TO_WIDTH'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                valid_prev_q;
    logic                frame_clear_q, frame_clear_d;
    logic [15:0]         src_q, src_d;
    logic [7:0]          hs_ctrl_q, hs_ctrl_d;
    logic [7:0]          hs_port_q, hs_port_d;
    logic [10:0]         hs_len_q, hs_len_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                irq_q, irq_d;
    logic                irq_set;
    logic [TO_WIDTH-1:0] timer_q, timer_d;
    logic                abort_q, abort_d;

    logic       new_frame;
    logic [7:0] scout_port;
    logic       scout_ok;
    logic       data_ok;
    logic       leave_after_tx;

    assign new_frame  = frame_valid & ~valid_prev_q;
    assign scout_port = frame_scout[7:0];
    assign scout_ok   = new_frame & enable & (frame_cnt <= SCOUT_MAX_C) &
                        (scout_port != 8'd0) &
                        ((listen_port == 8'd0) | (scout_port == listen_port));
    assign data_ok    = new_frame & (frame_src == src_q) & (frame_cnt > 11'd4);
    // A disable seen at any point during an ACK turns its completion into a quiet return to IDLE.
    assign leave_after_tx = abort_q | ~enable;

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        hs_ctrl_d     = hs_ctrl_q;
        hs_port_d     = hs_port_q;
        hs_len_d      = hs_len_q;
        err_code_d    = err_code_q;
        timer_d       = timer_q;
        abort_d       = abort_q;
        irq_set       = 1'b0;
        frame_clear_d = new_frame;

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (scout_ok) begin
                    src_d     = frame_src;
                    hs_ctrl_d = frame_scout[15:8];
                    hs_port_d = scout_port;
                    state_d   = ACK1;
                end
            end
            ACK1: begin
                if (!enable) abort_d = 1'b1;
                if (tx_err) begin
                    state_d    = IDLE;
                    err_code_d = 2'd2;
                    irq_set    = 1'b1;
                end else if (tx_done) begin
                    timer_d = '0;
                    state_d = leave_after_tx ? IDLE : WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                timer_d = timer_q + 1'b1;
                if (!enable) begin
                    state_d = IDLE;
                end else if (data_ok) begin
                    hs_len_d = frame_cnt - 11'd4;
                    state_d  = ACK2;
                end else if (timer_q == TO_LAST) begin
                    state_d    = IDLE;
                    err_code_d = 2'd1;
                    irq_set    = 1'b1;
                end
            end
            ACK2: begin
                if (!enable) abort_d = 1'b1;
                if (tx_err) begin
                    state_d    = IDLE;
                    err_code_d = 2'd3;
                    irq_set    = 1'b1;
                end else if (tx_done) begin
                    state_d = IDLE;
                    if (!leave_after_tx) begin
                        err_code_d = 2'd0;
                        irq_set    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        irq_d = irq_set | (irq_q & ~irq_ack);
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            valid_prev_q  <= 1'b0;
            frame_clear_q <= 1'b0;
            src_q         <= '0;
            hs_ctrl_q     <= '0;
            hs_port_q     <= '0;
            hs_len_q      <= '0;
            err_code_q    <= '0;
            irq_q         <= 1'b0;
            timer_q       <= '0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            valid_prev_q  <= frame_valid;
            frame_clear_q <= frame_clear_d;
            src_q         <= src_d;
            hs_ctrl_q     <= hs_ctrl_d;
            hs_port_q     <= hs_port_d;
            hs_len_q      <= hs_len_d;
            err_code_q    <= err_code_d;
            irq_q         <= irq_d;
            timer_q       <= timer_d;
            abort_q       <= abort_d;
        end
    end

    assign frame_clear = frame_clear_q;
    assign tx_req      = (state_q == ACK1) || (state_q == ACK2);
    assign tx_dst      = src_q;
    assign hs_ctrl     = hs_ctrl_q;
    assign hs_port     = hs_port_q;
    assign hs_len      = hs_len_q;
    assign err_code    = err_code_q;
    assign irq         = irq_q;
    assign state       = state_q;

endmodule

// File: tb/tb_econet_handshake_ctrl.sv
// Directed bench for econet_handshake_ctrl: full handshake, timeout, filtering,
// error paths, enable withdrawal and asynchronous reset.
module tb_econet_handshake_ctrl;

    localparam int TMO = 20;

    logic        sys_clk;
    logic        reset_n;
    logic        enable;
    logic [7:0]  listen_port;
    logic        frame_valid;
    logic [10:0] frame_cnt;
    logic [15:0] frame_src;
    logic [15:0] frame_scout;
    logic        frame_clear;
    logic        tx_req;
    logic [15:0] tx_dst;
    logic        tx_done;
    logic        tx_err;
    logic [7:0]  hs_ctrl;
    logic [7:0]  hs_port;
    logic [10:0] hs_len;
    logic [1:0]  err_code;
    logic        irq;
    logic        irq_ack;
    logic [2:0]  state;

    int checks   = 0;
    int failures = 0;

    econet_handshake_ctrl #(.SCOUT_MAX(8), .TO_WIDTH(8), .TIMEOUT(TMO)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .enable(enable), .listen_port(listen_port),
        .frame_valid(frame_valid), .frame_cnt(frame_cnt), .frame_src(frame_src),
        .frame_scout(frame_scout), .frame_clear(frame_clear), .tx_req(tx_req),
        .tx_dst(tx_dst), .tx_done(tx_done), .tx_err(tx_err), .hs_ctrl(hs_ctrl),
        .hs_port(hs_port), .hs_len(hs_len), .err_code(err_code), .irq(irq),
        .irq_ack(irq_ack), .state(state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] src, input logic [10:0] cnt,
                              input logic [7:0] ctrl, input logic [7:0] port);
        frame_src   = src;
        frame_cnt   = cnt;
        frame_scout = {ctrl, port};
        frame_valid = 1'b1;
        tick();
    endtask

    task automatic release_frame();
        frame_valid = 1'b0;
        tick();
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic pulse_err();
        tx_err = 1'b1;
        tick();
        tx_err = 1'b0;
    endtask

    task automatic ack_irq();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++; if (tx_req !== 1'b0 || frame_clear !== 1'b0 || irq !== 1'b0) begin failures++; $display("FAIL rst_ctrl got=%b%b%b exp=000", tx_req, frame_clear, irq); end
        checks++; if ({tx_dst, hs_ctrl, hs_port, hs_len, err_code} !== 45'd0) begin failures++; $display("FAIL rst_data got=%h exp=0", {tx_dst, hs_ctrl, hs_port, hs_len, err_code}); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_full();
        send_frame(16'h0102, 11'd6, 8'hA5, 8'h99);
        checks++; if (frame_clear !== 1'b1) begin failures++; $display("FAIL full_clr1 got=%b exp=1", frame_clear); end
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL full_ack1 got=%0d exp=1", state); end
        checks++; if (tx_req !== 1'b1 || tx_dst !== 16'h0102) begin failures++; $display("FAIL full_tx1 got=%b/%h exp=1/0102", tx_req, tx_dst); end
        checks++; if (hs_ctrl !== 8'hA5 || hs_port !== 8'h99) begin failures++; $display("FAIL full_latch got=%h/%h exp=a5/99", hs_ctrl, hs_port); end
        tick();
        checks++; if (frame_clear !== 1'b0 || tx_req !== 1'b1) begin failures++; $display("FAIL full_hold got=%b/%b exp=0/1", frame_clear, tx_req); end
        release_frame();
        pulse_done();
        checks++; if (state !== 3'd2 || tx_req !== 1'b0) begin failures++; $display("FAIL full_wait got=%0d/%b exp=2/0", state, tx_req); end
        send_frame(16'h0102, 11'd20, 8'h00, 8'h00);
        checks++; if (state !== 3'd3 || tx_req !== 1'b1 || tx_dst !== 16'h0102) begin failures++; $display("FAIL full_ack2 got=%0d/%b/%h exp=3/1/0102", state, tx_req, tx_dst); end
        checks++; if (hs_len !== 11'd16) begin failures++; $display("FAIL full_len got=%0d exp=16", hs_len); end
        release_frame();
        pulse_done();
        checks++; if (state !== 3'd0 || irq !== 1'b1 || err_code !== 2'd0 || tx_req !== 1'b0) begin failures++; $display("FAIL full_end got=%0d/%b/%0d/%b exp=0/1/0/0", state, irq, err_code, tx_req); end
        tick(); tick();
        checks++; if (irq !== 1'b1 || hs_len !== 11'd16 || hs_port !== 8'h99) begin failures++; $display("FAIL full_sticky got=%b/%0d/%h exp=1/16/99", irq, hs_len, hs_port); end
        ack_irq();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL full_irqack got=%b exp=0", irq); end
    endtask

    task automatic test_timeout();
        int n;
        send_frame(16'h0204, 11'd5, 8'h80, 8'h33);
        release_frame();
        pulse_done();
        n = 0;
        while (state !== 3'd0 && n < 100) begin
            tick();
            n++;
        end
        checks++; if (n !== TMO) begin failures++; $display("FAIL tmo_cycles got=%0d exp=%0d", n, TMO); end
        checks++; if (err_code !== 2'd1 || irq !== 1'b1) begin failures++; $display("FAIL tmo_err got=%0d/%b exp=1/1", err_code, irq); end
        ack_irq();
    endtask

    task automatic test_wrong_src();
        send_frame(16'h0102, 11'd4, 8'h81, 8'h44);
        release_frame();
        pulse_done();
        send_frame(16'h0305, 11'd20, 8'h00, 8'h00);
        checks++; if (frame_clear !== 1'b1 || state !== 3'd2) begin failures++; $display("FAIL wsrc_other got=%b/%0d exp=1/2", frame_clear, state); end
        release_frame();
        send_frame(16'h0102, 11'd4, 8'h00, 8'h00);
        checks++; if (frame_clear !== 1'b1 || state !== 3'd2) begin failures++; $display("FAIL wsrc_short got=%b/%0d exp=1/2", frame_clear, state); end
        release_frame();
        send_frame(16'h0102, 11'd5, 8'h00, 8'h00);
        checks++; if (state !== 3'd3 || hs_len !== 11'd1) begin failures++; $display("FAIL wsrc_good got=%0d/%0d exp=3/1", state, hs_len); end
        release_frame();
        pulse_done();
        checks++; if (state !== 3'd0 || irq !== 1'b1 || err_code !== 2'd0) begin failures++; $display("FAIL wsrc_end got=%0d/%b/%0d exp=0/1/0", state, irq, err_code); end
        ack_irq();
    endtask

    task automatic test_ack1_err();
        send_frame(16'h0A0B, 11'd8, 8'h82, 8'h55);
        release_frame();
        pulse_err();
        checks++; if (state !== 3'd0 || err_code !== 2'd2 || irq !== 1'b1 || tx_req !== 1'b0) begin failures++; $display("FAIL a1err got=%0d/%0d/%b/%b exp=0/2/1/0", state, err_code, irq, tx_req); end
        ack_irq();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL a1err_ack got=%b exp=0", irq); end
    endtask

    task automatic test_ack2_err_combined();
        send_frame(16'h0C0D, 11'd7, 8'h83, 8'h66);
        release_frame();
        pulse_done();
        send_frame(16'h0C0D, 11'd12, 8'h00, 8'h00);
        release_frame();
        tx_done = 1'b1; tx_err = 1'b1; irq_ack = 1'b1;
        tick();
        tx_done = 1'b0; tx_err = 1'b0; irq_ack = 1'b0;
        checks++; if (state !== 3'd0 || err_code !== 2'd3 || irq !== 1'b1) begin failures++; $display("FAIL a2err got=%0d/%0d/%b exp=0/3/1", state, err_code, irq); end
        checks++; if (hs_len !== 11'd8) begin failures++; $display("FAIL a2err_len got=%0d exp=8", hs_len); end
        ack_irq();
    endtask

    task automatic test_listen();
        listen_port = 8'h10;
        send_frame(16'h0102, 11'd6, 8'h80, 8'h11);
        checks++; if (frame_clear !== 1'b1 || state !== 3'd0 || tx_req !== 1'b0) begin failures++; $display("FAIL lst_port got=%b/%0d/%b exp=1/0/0", frame_clear, state, tx_req); end
        tick(); tick();
        checks++; if (frame_clear !== 1'b0 || tx_req !== 1'b0) begin failures++; $display("FAIL lst_level got=%b/%b exp=0/0", frame_clear, tx_req); end
        release_frame();
        send_frame(16'h0102, 11'd6, 8'h80, 8'h00);
        checks++; if (frame_clear !== 1'b1 || state !== 3'd0 || tx_req !== 1'b0) begin failures++; $display("FAIL lst_zero got=%b/%0d/%b exp=1/0/0", frame_clear, state, tx_req); end
        release_frame();
        send_frame(16'h0102, 11'd9, 8'h80, 8'h10);
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL lst_long got=%0d exp=0", state); end
        release_frame();
        send_frame(16'h0102, 11'd8, 8'h80, 8'h10);
        checks++; if (state !== 3'd1 || tx_req !== 1'b1) begin failures++; $display("FAIL lst_match got=%0d/%b exp=1/1", state, tx_req); end
        release_frame();
        pulse_err();
        ack_irq();
        listen_port = 8'h00;
    endtask

    task automatic test_enable();
        send_frame(16'h0707, 11'd6, 8'h84, 8'h21);
        release_frame();
        enable = 1'b0;
        tick();
        checks++; if (state !== 3'd1 || tx_req !== 1'b1) begin failures++; $display("FAIL en_ack1_hold got=%0d/%b exp=1/1", state, tx_req); end
        pulse_done();
        checks++; if (state !== 3'd0 || irq !== 1'b0) begin failures++; $display("FAIL en_ack1_done got=%0d/%b exp=0/0", state, irq); end
        enable = 1'b1;
        send_frame(16'h0707, 11'd6, 8'h84, 8'h21);
        release_frame();
        pulse_done();
        enable = 1'b0;
        tick();
        checks++; if (state !== 3'd0 || irq !== 1'b0) begin failures++; $display("FAIL en_wait got=%0d/%b exp=0/0", state, irq); end
        send_frame(16'h0707, 11'd6, 8'h84, 8'h21);
        checks++; if (state !== 3'd0 || frame_clear !== 1'b1) begin failures++; $display("FAIL en_idle got=%0d/%b exp=0/1", state, frame_clear); end
        release_frame();
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        send_frame(16'h0102, 11'd6, 8'hA5, 8'h99);
        release_frame();
        pulse_done();
        send_frame(16'h0102, 11'd20, 8'h00, 8'h00);
        checks++; if (tx_req !== 1'b1 || state !== 3'd3) begin failures++; $display("FAIL rmid_pre got=%b/%0d exp=1/3", tx_req, state); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (tx_req !== 1'b0 || state !== 3'd0 || frame_clear !== 1'b0 || irq !== 1'b0) begin failures++; $display("FAIL rmid_ctrl got=%b/%0d/%b/%b exp=0/0/0/0", tx_req, state, frame_clear, irq); end
        checks++; if ({tx_dst, hs_ctrl, hs_port, hs_len, err_code} !== 45'd0) begin failures++; $display("FAIL rmid_data got=%h exp=0", {tx_dst, hs_ctrl, hs_port, hs_len, err_code}); end
        #1 reset_n = 1'b1;
        tick();
        checks++; if (frame_clear !== 1'b1 || state !== 3'd0) begin failures++; $display("FAIL rmid_edge got=%b/%0d exp=1/0", frame_clear, state); end
        release_frame();
    endtask

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b1;
        listen_port = 8'h00;
        frame_valid = 1'b0;
        frame_cnt   = '0;
        frame_src   = '0;
        frame_scout = '0;
        tx_done     = 1'b0;
        tx_err      = 1'b0;
        irq_ack     = 1'b0;
        test_reset();
        test_full();
        test_timeout();
        test_wrong_src();
        test_ack1_err();
        test_ack2_err_combined();
        test_listen();
        test_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
